// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lsu_pkg                                                |
// | Description : Shared funct3 codes and FSM state type for the         |
// |               load/store unit in front of dmem.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package lsu_pkg;

  // RISC-V funct3 size/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lsu_align                                              |
// | Description : Combinational lane logic: load extension, sub-word     |
// |               store merge and misaligned/illegal classification.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        fault
);

  logic [4:0]  w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = {addr, 3'b000};
  assign w_byte  = word[w_shift +: 8];
  assign w_half  = addr[1] ? word[31:16] : word[15:0];

  // Decode funct3 into the extended load value, merged store word and fault
  always_comb begin
    fault      = 1'b0;
    load_val   = '0;
    store_word = wdata;
    case (funct3)
      F3_B: begin
        load_val                   = {{24{w_byte[7]}}, w_byte};
        store_word                 = word;
        store_word[w_shift +: 8]   = wdata[7:0];
      end
      F3_H: begin
        fault      = addr[0];
        load_val   = {{16{w_half[15]}}, w_half};
        store_word = addr[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      F3_W: begin
        fault    = (addr != 2'b00);
        load_val = word;
      end
      F3_BU: begin
        // unsigned variants exist only for loads
        fault    = we;
        load_val = {24'd0, w_byte};
      end
      F3_HU: begin
        fault    = we | addr[0];
        load_val = {16'd0, w_half};
      end
      default: fault = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lsu_dmem_if                                            |
// | Description : Load/store unit driving dmem. Turns byte/half/word     |
// |               requests into whole-word accesses with extension,      |
// |               read-modify-write and fault checking.                  |
// |               Optional macro LSU_PERF_CNT_EN adds load/store/fault   |
// |               event counters.                                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lsu_dmem_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       fault_cnt
`endif
);

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("lsu_dmem_if: only DATA_W = 32 is supported");
    end
  endgenerate

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_merge;

  logic              w_al_we;
  logic [2:0]        w_al_funct3;
  logic [1:0]        w_al_addr;
  logic [DATA_W-1:0] w_al_word;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_store_word;
  logic              w_fault;

  // In IDLE the classifier looks at the incoming request so a fault can be
  // decided at acceptance; afterwards it works on the frozen copy.
  assign w_al_we     = (r_state == IDLE) ? req_we     : r_we;
  assign w_al_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_al_addr   = (r_state == IDLE) ? req_addr[1:0] : r_addr[1:0];
  assign w_al_word   = (r_state == MERGE) ? r_merge : mem_rdata;

  lsu_align u_align (
    .we         (w_al_we),
    .funct3     (w_al_funct3),
    .addr       (w_al_addr),
    .word       (w_al_word),
    .wdata      (r_wdata),
    .load_val   (w_load_val),
    .store_word (w_store_word),
    .fault      (w_fault)
  );

  assign mem_addr = {r_addr[ADDR_W-1:2], 2'b00};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake/memory strobes
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_fault ? RESP : ACCESS;
      end
      ACCESS: begin
        if (r_we && (r_funct3 == F3_W)) begin
          mem_we    = 1'b1;
          mem_wdata = r_wdata;
          w_next    = RESP;
        end else if (r_we) begin
          w_next = MERGE;
        end else begin
          w_next = RESP;
        end
      end
      MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = w_store_word;
        w_next    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture, merge word and response data (updated only when entering RESP)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_merge   <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_fault) begin
              rsp_rdata <= '0;
              rsp_fault <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!r_we) begin
            rsp_rdata <= w_load_val;
            rsp_fault <= 1'b0;
          end else if (r_funct3 == F3_W) begin
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
          end else begin
            r_merge <= mem_rdata;
          end
        end
        MERGE: begin
          rsp_rdata <= '0;
          rsp_fault <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  // Count each completed transaction once, faults only in fault_cnt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      fault_cnt <= '0;
    end else if (r_state == RESP) begin
      if (rsp_fault)  fault_cnt <= fault_cnt + 32'd1;
      else if (r_we)  store_cnt <= store_cnt + 32'd1;
      else            load_cnt  <= load_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
